btn_debounce_fsm: RTL and testbench

- FSM-based push-button conditioner that sits directly upstream of the stopwatch core.
- Takes a raw, bouncing, asynchronous board button (btnC or a switch) and produces a clean debounced level plus single-cycle rise, fall and long-press ticks.
- Stopwatch go/clr and display controls consume these ticks in place of raw pins.

---
 rtl/btn_debounce_fsm.sv | 115 +++++++++++
 tb/tb_btn_debounce_fsm.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_fsm.sv
// rtl/btn_debounce_fsm.sv - push-button synchronizer/debouncer with rise, fall and long-press ticks
module btn_debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 2000000,
  parameter int unsigned LONG_CYCLES   = 100000000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic long_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INC     = CNT_W'(1);

  state_t           state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] stable_cnt_q;
  logic [CNT_W-1:0] long_cnt_q;
  logic             db_level_q;
  logic             rise_q;
  logic             fall_q;
  logic             long_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ZERO;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_cnt_q <= '0;
      long_cnt_q   <= '0;
      db_level_q   <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;

      case (state_q)
        ZERO: begin
          if (sync2_q) begin
            state_q      <= WAIT1;
            stable_cnt_q <= '0;
          end
        end

        WAIT1: begin
          if (!sync2_q) begin
            state_q <= ZERO;
          end else if (stable_cnt_q == STABLE_LAST) begin
            state_q    <= ONE;
            db_level_q <= 1'b1;
            rise_q     <= 1'b1;
            long_cnt_q <= '0;
          end else begin
            stable_cnt_q <= stable_cnt_q + CNT_INC;
          end
        end

        ONE: begin
          // Saturating at LONG_CYCLES means the == LONG_LAST match happens once per press.
          if (long_cnt_q != LONG_MAX) begin
            long_cnt_q <= long_cnt_q + CNT_INC;
          end
          if (long_cnt_q == LONG_LAST) begin
            long_q <= 1'b1;
          end
          if (!sync2_q) begin
            state_q      <= WAIT0;
            stable_cnt_q <= '0;
          end
        end

        WAIT0: begin
          if (sync2_q) begin
            state_q <= ONE;
          end else if (stable_cnt_q == STABLE_LAST) begin
            state_q    <= ZERO;
            db_level_q <= 1'b0;
            fall_q     <= 1'b1;
          end else begin
            stable_cnt_q <= stable_cnt_q + CNT_INC;
          end
        end

        default: begin
          state_q <= ZERO;
        end
      endcase
    end
  end

  assign db_level  = db_level_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign long_tick = long_q;

endmodule

// File: tb/tb_btn_debounce_fsm.sv
// tb/tb_btn_debounce_fsm.sv - directed scoreboard bench for btn_debounce_fsm
module tb_btn_debounce_fsm;

  logic clk;
  logic reset;
  logic btn_in;
  logic db_level;
  logic rise_tick;
  logic fall_tick;
  logic long_tick;

  int    vectors;
  int    miscompares;
  int    cycle;
  string phase;

  // Expected {db_level, rise_tick, fall_tick, long_tick}
  logic [3:0] exp_q[$];

  localparam logic [3:0] E_LO   = 4'b0000;
  localparam logic [3:0] E_HI   = 4'b1000;
  localparam logic [3:0] E_RISE = 4'b1100;
  localparam logic [3:0] E_FALL = 4'b0010;
  localparam logic [3:0] E_LONG = 4'b1001;

  btn_debounce_fsm #(
    .STABLE_CYCLES(8),
    .LONG_CYCLES  (32),
    .CNT_W        (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .db_level (db_level),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .long_tick(long_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now();
    logic [3:0] obs;
    logic [3:0] e;
    obs = {db_level, rise_tick, fall_tick, long_tick};
    e   = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed lvl/rise/fall/long=%b expected %b", phase, cycle, obs, e);
    end
  endtask

  task automatic step(input logic b, input logic [3:0] e);
    btn_in = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    check_now();
  endtask

  task automatic hold(input int n, input logic b, input logic [3:0] e);
    for (int i = 0; i < n; i++) step(b, e);
  endtask

  // Assert reset between edges, check outputs clear with no edge, then release.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(E_LO);
    check_now();
    @(posedge clk);
    #1;
    exp_q.push_back(E_LO);
    check_now();
    reset  = 1'b0;
    cycle  = 0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    reset       = 1'b0;
    btn_in      = 1'b0;

    phase = "reset";
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(E_LO);
    check_now();
    @(posedge clk);
    #1;
    exp_q.push_back(E_LO);
    check_now();
    reset = 1'b0;

    phase = "idle";
    hold(20, 1'b0, E_LO);

    phase = "clean_press";
    cycle = 0;
    hold(10, 1'b1, E_LO);
    step(1'b1, E_RISE);
    hold(31, 1'b1, E_HI);
    step(1'b1, E_LONG);
    hold(7, 1'b1, E_HI);

    phase = "clean_release";
    cycle = 0;
    hold(10, 1'b0, E_HI);
    step(1'b0, E_FALL);
    hold(5, 1'b0, E_LO);

    phase = "bounce";
    cycle = 0;
    hold(3, 1'b1, E_LO);
    hold(3, 1'b0, E_LO);
    hold(3, 1'b1, E_LO);
    hold(3, 1'b0, E_LO);
    hold(10, 1'b1, E_LO);
    step(1'b1, E_RISE);
    hold(31, 1'b1, E_HI);
    step(1'b1, E_LONG);
    hold(8, 1'b1, E_HI);

    phase = "low_glitch";
    cycle = 0;
    hold(4, 1'b0, E_HI);
    hold(40, 1'b1, E_HI);

    phase = "release_after_glitch";
    cycle = 0;
    hold(10, 1'b0, E_HI);
    step(1'b0, E_FALL);
    hold(5, 1'b0, E_LO);

    phase = "reset_mid_wait1";
    cycle = 0;
    hold(8, 1'b1, E_LO);
    async_reset();
    hold(10, 1'b1, E_LO);
    step(1'b1, E_RISE);

    phase = "reset_mid_one";
    hold(20, 1'b1, E_HI);
    async_reset();
    hold(10, 1'b1, E_LO);
    step(1'b1, E_RISE);
    hold(31, 1'b1, E_HI);
    step(1'b1, E_LONG);
    hold(5, 1'b1, E_HI);

    phase = "release_after_reset";
    cycle = 0;
    hold(10, 1'b0, E_HI);
    step(1'b0, E_FALL);
    hold(3, 1'b0, E_LO);

    phase = "short_press";
    cycle = 0;
    hold(10, 1'b1, E_LO);
    step(1'b0, E_RISE);
    hold(9, 1'b0, E_HI);
    step(1'b0, E_FALL);
    hold(40, 1'b0, E_LO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
